mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory bus between the CPU instruction (Iw*) and data (Dw*) buses.
//  Sits between the CPU top level and the memory/bus fabric in MULTICICLO and PIPELINE builds with unified memory.
//  Serialises requests one at a time and stalls the losing requester.
//  Data priority applies, with a starvation guard for instruction fetch.
// PARAMETERS
//  ADDR_W        32  address width (all ports)
//  DATA_W        32  data width (all ports)
//  STARVE_LIMIT  4   consecutive D grants with I pending before I is forced; 1..15
// PORTS
//  iCLK          in   1       clock; all logic rising-edge
//  iRST          in   1       reset, synchronous, active-high
//  IwReadEnable  in   1       instr request read (held until oIDone)
//  IwWriteEnable in   1       instr request write (held until oIDone)
//  IwByteEnable  in   4       instr byte lanes
//  IwAddress     in   ADDR_W  instr address
//  IwWriteData   in   DATA_W  instr write data
//  oIReadData    out  DATA_W  instr read data, valid when oIDone=1, held after
//  oIDone        out  1       1-cycle completion pulse, instr port
//  oIStall       out  1       (IwReadEnable|IwWriteEnable) & ~oIDone
//  DwReadEnable, DwWriteEnable, DwByteEnable, DwAddress, DwWriteData  in  same as I port, data side
//  oDReadData, oDDone, oDStall  out  same as I port, data side
//  MwReadEnable  out  1       memory read strobe
//  MwWriteEnable out  1       memory write strobe
//  MwByteEnable  out  4       memory byte lanes
//  MwAddress     out  ADDR_W  memory address
//  MwWriteData   out  DATA_W  memory write data
//  iMemReady     in   1       memory accepted/completed access this cycle
//  iMemReadData  in   DATA_W  valid when iMemReady & MwReadEnable
//  oGrant        out  2       01=I, 10=D, 00=none (monitoring)
// BEHAVIOUR
//  Reset: FSM=IDLE; starve cnt=0; all outputs 0, including read-data registers.
//  FSM states:
//   IDLE   -> BUSY_D if D req & (~I req | cnt<STARVE_LIMIT); -> BUSY_I if I req & (~D req | cnt==STARVE_LIMIT)
//   BUSY_x -> Mw* driven combinationally from the granted port's inputs; memory strobe = that port's R/W enable
//          -> RESP_x on the edge where iMemReady=1; read data registered on that edge
//   RESP_x -> oxDone=1 for exactly this cycle; Mw strobes 0; -> IDLE unconditionally
//  Requests are sampled only in IDLE; the RESP bubble stops a still-held request being regranted.
//  Latency: req in IDLE at cycle 0, grant cycle 1; iMemReady in cycle 1 gives done in cycle 2. Min 3 cycles/access.
//  Starve counter: +1 (saturating) on each IDLE->BUSY_D while I req=1; cleared on IDLE->BUSY_I.
//  Read & write both set on a port: write wins; strobe MwWriteEnable only; read data not updated.
//  Requester drops request mid-BUSY (protocol violation): the access still completes and done pulses; no retry.
//  iMemReady outside BUSY_x: ignored.
//  iRST mid-access: next edge returns to IDLE with strobes 0; the in-flight access is abandoned with no done.
//  oxReadData holds its value until the next read completion on that port.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined: adds outputs oPerfIStall[31:0] and oPerfDStall[31:0].
//   - Each counter increments on every cycle its oxStall=1 and wraps at 2^32.
//   - Both counters clear on iRST.
//  Not defined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  D only: DwRead @0x100, iMemReady next cycle, data 0xDEADBEEF -> oDDone cycle 2, oDReadData=0xDEADBEEF, oIStall=0.
//  Both req held, ready every BUSY cycle -> grants D,D,D,D,I (STARVE_LIMIT=4), then the counter clears.
//  DwWrite BE=4'b0011 @0x2000 data 0x1234 -> MwWriteEnable=1, MwByteEnable=0011, MwAddress=0x2000; no read-data change.
//  iMemReady held low 10 cycles in BUSY_I -> oIStall=1 throughout, Mw* stable; done 1 cycle after ready.
//  iRST pulse during BUSY_D -> next cycle all outputs 0, FSM=IDLE, no oDDone.
//  ARB_PERF_CNT_EN: 5-cycle D stall -> oPerfDStall=5.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter sharing one bus between instruction and data ports.
// Data has priority; STARVE_LIMIT forces an instruction grant. Optional: ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              IwReadEnable,
    input  logic              IwWriteEnable,
    input  logic [3:0]        IwByteEnable,
    input  logic [ADDR_W-1:0] IwAddress,
    input  logic [DATA_W-1:0] IwWriteData,
    output logic [DATA_W-1:0] oIReadData,
    output logic              oIDone,
    output logic              oIStall,
    input  logic              DwReadEnable,
    input  logic              DwWriteEnable,
    input  logic [3:0]        DwByteEnable,
    input  logic [ADDR_W-1:0] DwAddress,
    input  logic [DATA_W-1:0] DwWriteData,
    output logic [DATA_W-1:0] oDReadData,
    output logic              oDDone,
    output logic              oDStall,
    output logic              MwReadEnable,
    output logic              MwWriteEnable,
    output logic [3:0]        MwByteEnable,
    output logic [ADDR_W-1:0] MwAddress,
    output logic [DATA_W-1:0] MwWriteData,
    input  logic              iMemReady,
    input  logic [DATA_W-1:0] iMemReadData,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       oPerfIStall,
    output logic [31:0]       oPerfDStall,
`endif
    output logic [1:0]        oGrant
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP_I,
        RESP_D
    } state_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic [1:0]        grant_q;
    logic              idone_q;
    logic              ddone_q;
    logic [DATA_W-1:0] ird_q;
    logic [DATA_W-1:0] drd_q;

    logic i_req;
    logic d_req;
    logic i_rd;
    logic d_rd;

    assign i_req = IwReadEnable | IwWriteEnable;
    assign d_req = DwReadEnable | DwWriteEnable;
    // A simultaneous write request suppresses the read
    assign i_rd  = IwReadEnable & ~IwWriteEnable;
    assign d_rd  = DwReadEnable & ~DwWriteEnable;
    assign cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    // Arbitration FSM with registered grant, done pulses and read data
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            idone_q <= 1'b0;
            ddone_q <= 1'b0;
            ird_q   <= '0;
            drd_q   <= '0;
        end else begin
            idone_q <= 1'b0;
            ddone_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (d_req && (!i_req || cnt_q < LIM)) begin
                        state_q <= BUSY_D;
                        grant_q <= 2'b10;
                        if (i_req) cnt_q <= cnt_d;
                    end else if (i_req) begin
                        state_q <= BUSY_I;
                        grant_q <= 2'b01;
                        cnt_q   <= '0;
                    end
                end
                BUSY_I: begin
                    if (iMemReady) begin
                        state_q <= RESP_I;
                        grant_q <= 2'b00;
                        idone_q <= 1'b1;
                        if (i_rd) ird_q <= iMemReadData;
                    end
                end
                BUSY_D: begin
                    if (iMemReady) begin
                        state_q <= RESP_D;
                        grant_q <= 2'b00;
                        ddone_q <= 1'b1;
                        if (d_rd) drd_q <= iMemReadData;
                    end
                end
                RESP_I, RESP_D: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    // Memory bus follows the granted port's live inputs
    always_comb begin
        MwReadEnable  = 1'b0;
        MwWriteEnable = 1'b0;
        MwByteEnable  = '0;
        MwAddress     = '0;
        MwWriteData   = '0;
        if (grant_q[0]) begin
            MwReadEnable  = i_rd;
            MwWriteEnable = IwWriteEnable;
            MwByteEnable  = IwByteEnable;
            MwAddress     = IwAddress;
            MwWriteData   = IwWriteData;
        end else if (grant_q[1]) begin
            MwReadEnable  = d_rd;
            MwWriteEnable = DwWriteEnable;
            MwByteEnable  = DwByteEnable;
            MwAddress     = DwAddress;
            MwWriteData   = DwWriteData;
        end
    end

    assign oGrant     = grant_q;
    assign oIDone     = idone_q;
    assign oDDone     = ddone_q;
    assign oIReadData = ird_q;
    assign oDReadData = drd_q;
    assign oIStall    = i_req & ~idone_q;
    assign oDStall    = d_req & ~ddone_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_i_q;
    logic [31:0] perf_d_q;

    // Free-running stall cycle counters, wrapping naturally
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            perf_i_q <= '0;
            perf_d_q <= '0;
        end else begin
            if (oIStall) perf_i_q <= perf_i_q + 32'd1;
            if (oDStall) perf_d_q <= perf_d_q + 32'd1;
        end
    end

    assign oPerfIStall = perf_i_q;
    assign oPerfDStall = perf_d_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LIM = 4;

    logic        iCLK;
    logic        iRST;
    logic        IwReadEnable, IwWriteEnable;
    logic [3:0]  IwByteEnable;
    logic [31:0] IwAddress, IwWriteData, oIReadData;
    logic        oIDone, oIStall;
    logic        DwReadEnable, DwWriteEnable;
    logic [3:0]  DwByteEnable;
    logic [31:0] DwAddress, DwWriteData, oDReadData;
    logic        oDDone, oDStall;
    logic        MwReadEnable, MwWriteEnable;
    logic [3:0]  MwByteEnable;
    logic [31:0] MwAddress, MwWriteData;
    logic        iMemReady;
    logic [31:0] iMemReadData;
    logic [1:0]  oGrant;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] oPerfIStall, oPerfDStall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .IwReadEnable(IwReadEnable), .IwWriteEnable(IwWriteEnable),
        .IwByteEnable(IwByteEnable), .IwAddress(IwAddress),
        .IwWriteData(IwWriteData), .oIReadData(oIReadData),
        .oIDone(oIDone), .oIStall(oIStall),
        .DwReadEnable(DwReadEnable), .DwWriteEnable(DwWriteEnable),
        .DwByteEnable(DwByteEnable), .DwAddress(DwAddress),
        .DwWriteData(DwWriteData), .oDReadData(oDReadData),
        .oDDone(oDDone), .oDStall(oDStall),
        .MwReadEnable(MwReadEnable), .MwWriteEnable(MwWriteEnable),
        .MwByteEnable(MwByteEnable), .MwAddress(MwAddress),
        .MwWriteData(MwWriteData), .iMemReady(iMemReady),
        .iMemReadData(iMemReadData),
`ifdef ARB_PERF_CNT_EN
        .oPerfIStall(oPerfIStall), .oPerfDStall(oPerfDStall),
`endif
        .oGrant(oGrant)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr_inputs();
        IwReadEnable = 0; IwWriteEnable = 0; IwByteEnable = 0;
        IwAddress = 0; IwWriteData = 0;
        DwReadEnable = 0; DwWriteEnable = 0; DwByteEnable = 0;
        DwAddress = 0; DwWriteData = 0;
        iMemReady = 0; iMemReadData = 0;
    endtask

    task automatic do_reset();
        clr_inputs();
        iRST = 1;
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({oGrant, oIDone, oDDone, oIStall, oDStall} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {oGrant, oIDone, oDDone, oIStall, oDStall});
        end
        n_cmp++;
        if ({oIReadData, oDReadData} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h expected 0",
                     {oIReadData, oDReadData});
        end
        n_cmp++;
        if ({MwReadEnable, MwWriteEnable, MwByteEnable, MwAddress, MwWriteData} !== '0) begin
            n_err++;
            $display("FAIL reset_mem: got rd=%b wr=%b addr=%h expected zeros",
                     MwReadEnable, MwWriteEnable, MwAddress);
        end
    endtask

    task automatic test_d_read();
        do_reset();
        DwReadEnable = 1; DwAddress = 32'h100; DwByteEnable = 4'hF;
        @(negedge iCLK);
        n_cmp++;
        if (oGrant !== 2'b10 || MwReadEnable !== 1'b1 || MwAddress !== 32'h100) begin
            n_err++;
            $display("FAIL dread_grant: got g=%b rd=%b addr=%h expected g=10 rd=1 addr=100",
                     oGrant, MwReadEnable, MwAddress);
        end
        n_cmp++;
        if (oIStall !== 1'b0 || oDStall !== 1'b1) begin
            n_err++;
            $display("FAIL dread_stall: got i=%b d=%b expected i=0 d=1", oIStall, oDStall);
        end
        iMemReady = 1; iMemReadData = 32'hDEADBEEF;
        @(negedge iCLK);
        n_cmp++;
        if (oDDone !== 1'b1 || oDReadData !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL dread_done: got done=%b data=%h expected done=1 data=deadbeef",
                     oDDone, oDReadData);
        end
        n_cmp++;
        if (MwReadEnable !== 1'b0 || oGrant !== 2'b00 || oDStall !== 1'b0 || oIStall !== 1'b0) begin
            n_err++;
            $display("FAIL dread_resp: got rd=%b g=%b dst=%b ist=%b expected 0 00 0 0",
                     MwReadEnable, oGrant, oDStall, oIStall);
        end
        DwReadEnable = 0; iMemReady = 0; iMemReadData = 0;
        @(negedge iCLK);
        n_cmp++;
        if (oDDone !== 1'b0 || oDReadData !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL dread_hold: got done=%b data=%h expected done=0 data=deadbeef",
                     oDDone, oDReadData);
        end
    endtask

    task automatic test_write();
        DwReadEnable = 1; DwWriteEnable = 1; DwByteEnable = 4'b0011;
        DwAddress = 32'h2000; DwWriteData = 32'h1234;
        @(negedge iCLK);
        n_cmp++;
        if (MwWriteEnable !== 1'b1 || MwReadEnable !== 1'b0) begin
            n_err++;
            $display("FAIL write_strobe: got wr=%b rd=%b expected wr=1 rd=0",
                     MwWriteEnable, MwReadEnable);
        end
        n_cmp++;
        if (MwByteEnable !== 4'b0011 || MwAddress !== 32'h2000 || MwWriteData !== 32'h1234) begin
            n_err++;
            $display("FAIL write_bus: got be=%b addr=%h data=%h expected 0011 2000 1234",
                     MwByteEnable, MwAddress, MwWriteData);
        end
        iMemReady = 1; iMemReadData = 32'h55555555;
        @(negedge iCLK);
        n_cmp++;
        if (oDDone !== 1'b1 || oDReadData !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL write_done: got done=%b data=%h expected done=1 data=deadbeef",
                     oDDone, oDReadData);
        end
        clr_inputs();
        @(negedge iCLK);
    endtask

    task automatic test_stall_i();
        do_reset();
        IwReadEnable = 1; IwAddress = 32'h40; IwByteEnable = 4'hF;
        @(negedge iCLK);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (oIStall !== 1'b1 || oGrant !== 2'b01 || MwAddress !== 32'h40 ||
                MwReadEnable !== 1'b1 || oIDone !== 1'b0) begin
                n_err++;
                $display("FAIL istall_wait[%0d]: got st=%b g=%b addr=%h rd=%b expected 1 01 40 1",
                         i, oIStall, oGrant, MwAddress, MwReadEnable);
            end
            @(negedge iCLK);
        end
        iMemReady = 1; iMemReadData = 32'hCAFEF00D;
        @(negedge iCLK);
        n_cmp++;
        if (oIDone !== 1'b1 || oIReadData !== 32'hCAFEF00D || oIStall !== 1'b0) begin
            n_err++;
            $display("FAIL istall_done: got done=%b data=%h st=%b expected 1 cafef00d 0",
                     oIDone, oIReadData, oIStall);
        end
        clr_inputs();
        @(negedge iCLK);
    endtask

    task automatic test_starve();
        logic [1:0] g [10];
        int ng = 0;
        do_reset();
        IwReadEnable = 1; IwAddress = 32'h8;
        DwReadEnable = 1; DwAddress = 32'h80;
        for (int c = 0; c < 80 && ng < 10; c++) begin
            @(negedge iCLK);
            if (oGrant != 2'b00) begin
                g[ng] = oGrant;
                ng++;
                iMemReady = 1;
            end else begin
                iMemReady = 0;
            end
        end
        n_cmp++;
        if (ng != 10) begin
            n_err++;
            $display("FAIL starve_timeout: got %0d grants expected 10", ng);
        end
        for (int k = 0; k < ng; k++) begin
            n_cmp++;
            if (g[k] !== ((k % (LIM + 1) == LIM) ? 2'b01 : 2'b10)) begin
                n_err++;
                $display("FAIL starve_seq[%0d]: got %b expected %b", k, g[k],
                         (k % (LIM + 1) == LIM) ? 2'b01 : 2'b10);
            end
        end
        clr_inputs();
        @(negedge iCLK);
        @(negedge iCLK);
    endtask

    task automatic test_reset_mid();
        do_reset();
        DwReadEnable = 1; DwAddress = 32'h300;
        @(negedge iCLK);
        n_cmp++;
        if (oGrant !== 2'b10) begin
            n_err++;
            $display("FAIL rstmid_grant: got %b expected 10", oGrant);
        end
        iRST = 1;
        @(negedge iCLK);
        n_cmp++;
        if (oGrant !== 2'b00 || MwReadEnable !== 1'b0 || MwWriteEnable !== 1'b0 ||
            MwAddress !== 32'h0 || oDDone !== 1'b0 || oDReadData !== 32'h0) begin
            n_err++;
            $display("FAIL rstmid_outs: got g=%b rd=%b wr=%b addr=%h done=%b expected zeros",
                     oGrant, MwReadEnable, MwWriteEnable, MwAddress, oDDone);
        end
        iRST = 0; DwReadEnable = 0; iMemReady = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            n_cmp++;
            if (oDDone !== 1'b0 || oGrant !== 2'b00) begin
                n_err++;
                $display("FAIL rstmid_nodone[%0d]: got done=%b g=%b expected 0 00",
                         i, oDDone, oGrant);
            end
        end
        clr_inputs();
    endtask

`ifdef ARB_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        DwReadEnable = 1; DwAddress = 32'h500;
        repeat (4) @(negedge iCLK);
        iMemReady = 1;
        @(negedge iCLK);
        n_cmp++;
        if (oPerfDStall !== 32'd5 || oPerfIStall !== 32'd0) begin
            n_err++;
            $display("FAIL perf_cnt: got d=%0d i=%0d expected d=5 i=0",
                     oPerfDStall, oPerfIStall);
        end
        clr_inputs();
        @(negedge iCLK);
    endtask
`endif

    task automatic test_random();
        int         ph = 0;
        bit         mport = 0;
        int         cnt = 0;
        logic [31:0] erd_i = 0, erd_d = 0;
        logic [1:0] eg = 0;
        logic       eid = 0, edd = 0;
        logic       wr, rd;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            n_cmp++;
            if (oGrant !== eg || oIDone !== eid || oDDone !== edd) begin
                n_err++;
                $display("FAIL rand_ctrl@%0d: got g=%b id=%b dd=%b expected g=%b id=%b dd=%b",
                         cyc, oGrant, oIDone, oDDone, eg, eid, edd);
            end
            n_cmp++;
            if (oIReadData !== erd_i || oDReadData !== erd_d) begin
                n_err++;
                $display("FAIL rand_rdata@%0d: got i=%h d=%h expected i=%h d=%h",
                         cyc, oIReadData, oDReadData, erd_i, erd_d);
            end
            n_cmp++;
            if (oIStall !== ((IwReadEnable | IwWriteEnable) & ~eid) ||
                oDStall !== ((DwReadEnable | DwWriteEnable) & ~edd)) begin
                n_err++;
                $display("FAIL rand_stall@%0d: got i=%b d=%b", cyc, oIStall, oDStall);
            end
            if (ph == 1) begin
                wr = mport ? DwWriteEnable : IwWriteEnable;
                rd = (mport ? DwReadEnable : IwReadEnable) & ~wr;
                n_cmp++;
                if (MwWriteEnable !== wr || MwReadEnable !== rd ||
                    MwAddress !== (mport ? DwAddress : IwAddress) ||
                    MwByteEnable !== (mport ? DwByteEnable : IwByteEnable) ||
                    MwWriteData !== (mport ? DwWriteData : IwWriteData)) begin
                    n_err++;
                    $display("FAIL rand_bus@%0d: got rd=%b wr=%b addr=%h expected rd=%b wr=%b",
                             cyc, MwReadEnable, MwWriteEnable, MwAddress, rd, wr);
                end
            end else begin
                n_cmp++;
                if (MwReadEnable !== 1'b0 || MwWriteEnable !== 1'b0) begin
                    n_err++;
                    $display("FAIL rand_idlebus@%0d: got rd=%b wr=%b expected 0 0",
                             cyc, MwReadEnable, MwWriteEnable);
                end
            end
            if (eid) begin IwReadEnable = 0; IwWriteEnable = 0; end
            if (edd) begin DwReadEnable = 0; DwWriteEnable = 0; end
            if (!(IwReadEnable | IwWriteEnable) && $urandom_range(0, 2) == 0) begin
                {IwWriteEnable, IwReadEnable} = 2'($urandom_range(1, 3));
                IwAddress = $urandom; IwByteEnable = 4'($urandom);
                IwWriteData = $urandom;
            end
            if (!(DwReadEnable | DwWriteEnable) && $urandom_range(0, 2) == 0) begin
                {DwWriteEnable, DwReadEnable} = 2'($urandom_range(1, 3));
                DwAddress = $urandom; DwByteEnable = 4'($urandom);
                DwWriteData = $urandom;
            end
            iMemReady = ($urandom_range(0, 2) == 0);
            iMemReadData = $urandom;
            case (ph)
                0: begin
                    if ((DwReadEnable | DwWriteEnable) &&
                        (!(IwReadEnable | IwWriteEnable) || cnt < LIM)) begin
                        ph = 1; mport = 1;
                        if ((IwReadEnable | IwWriteEnable) && cnt < 15) cnt++;
                    end else if (IwReadEnable | IwWriteEnable) begin
                        ph = 1; mport = 0; cnt = 0;
                    end
                end
                1: begin
                    if (iMemReady) begin
                        ph = 2;
                        if (mport && DwReadEnable && !DwWriteEnable) erd_d = iMemReadData;
                        if (!mport && IwReadEnable && !IwWriteEnable) erd_i = iMemReadData;
                    end
                end
                default: ph = 0;
            endcase
            eg  = (ph == 1) ? (mport ? 2'b10 : 2'b01) : 2'b00;
            eid = (ph == 2) && !mport;
            edd = (ph == 2) && mport;
            @(negedge iCLK);
        end
        clr_inputs();
    endtask

    initial begin
        iRST = 1;
        clr_inputs();
        test_reset();
        test_d_read();
        test_write();
        test_stall_i();
        test_starve();
        test_reset_mid();
`ifdef ARB_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
